datagram_assembler: RTL

Receive-side frame controller between the UART byte receiver and `control_core`.
- Hunts for a sync byte and collects a fixed number of payload bytes into one `datagram` word.
- Optionally checks a trailing XOR checksum.
- Presents each good frame to the consumer over a valid/ready handshake, with a one-entry holding buffer.
- Rejects malformed, stalled and overrun frames and counts them in a saturating error counter.

---
 rtl/datagram_assembler.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/datagram_assembler.sv
// Receive-side frame assembler: hunts SYNC_BYTE, packs MSG_BYTES payload bytes into datagram, valid/ready out.
// Define DATAGRAM_CHECKSUM_EN to require a trailing XOR checksum byte after the payload.
module datagram_assembler #(
  parameter int unsigned MSG_BYTES      = 4,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic [MSG_BYTES*8-1:0] datagram,
  output logic                   dg_valid,
  input  logic                   dg_ready,
  output logic                   busy,
  output logic [7:0]             err_cnt
);

  localparam int unsigned MESSAGE_SIZE = MSG_BYTES * 8;
  localparam int unsigned IDX_W        = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;
  localparam int unsigned TO_W         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_BYTES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

`ifdef DATAGRAM_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK} state_t;
`else
  typedef enum logic [1:0] {IDLE, PAYLOAD} state_t;
`endif

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic [TO_W-1:0]         tcnt;
  logic [MESSAGE_SIZE-1:0] asm_q;
`ifdef DATAGRAM_CHECKSUM_EN
  logic [7:0]              csum;
  logic                    csum_bad_c;
`endif

  logic [MESSAGE_SIZE-1:0] shifted_c;
  logic [MESSAGE_SIZE-1:0] commit_data_c;
  logic                    timeout_c;
  logic                    commit_c;
  logic                    load_c;
  logic                    err_inc_c;

  // Frame events for this cycle; the timeout fires on the idle cycle that would make the count reach the limit
  always_comb begin
    shifted_c     = MESSAGE_SIZE'({asm_q, rx_data});
    timeout_c     = (state != IDLE) && !rx_valid && (tcnt == TO_LAST);
`ifdef DATAGRAM_CHECKSUM_EN
    commit_data_c = asm_q;
    commit_c      = (state == CHECK) && rx_valid && (rx_data == csum);
    csum_bad_c    = (state == CHECK) && rx_valid && (rx_data != csum);
`else
    commit_data_c = shifted_c;
    commit_c      = (state == PAYLOAD) && rx_valid && (idx == LAST_IDX);
`endif
    load_c        = commit_c && (!dg_valid || dg_ready);
    err_inc_c     = timeout_c || (commit_c && !load_c);
`ifdef DATAGRAM_CHECKSUM_EN
    err_inc_c     = err_inc_c || csum_bad_c;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      idx      <= '0;
      tcnt     <= '0;
      asm_q    <= '0;
      datagram <= '0;
      dg_valid <= 1'b0;
      busy     <= 1'b0;
      err_cnt  <= '0;
`ifdef DATAGRAM_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      // Output holding buffer: a commit refills it, otherwise an accept drains it
      if (load_c) begin
        datagram <= commit_data_c;
        dg_valid <= 1'b1;
      end else if (dg_ready) begin
        dg_valid <= 1'b0;
      end

      if (err_inc_c && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end

      if (timeout_c) begin
        state <= IDLE;
        busy  <= 1'b0;
        tcnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            tcnt <= '0;
            if (rx_valid && (rx_data == SYNC_BYTE)) begin
              state <= PAYLOAD;
              busy  <= 1'b1;
              idx   <= '0;
`ifdef DATAGRAM_CHECKSUM_EN
              csum  <= '0;
`endif
            end
          end
          PAYLOAD: begin
            if (rx_valid) begin
              asm_q <= shifted_c;
              idx   <= idx + IDX_W'(1);
              tcnt  <= '0;
`ifdef DATAGRAM_CHECKSUM_EN
              csum  <= csum ^ rx_data;
              if (idx == LAST_IDX) begin
                state <= CHECK;
              end
`else
              if (idx == LAST_IDX) begin
                state <= IDLE;
                busy  <= 1'b0;
              end
`endif
            end else begin
              tcnt <= tcnt + TO_W'(1);
            end
          end
`ifdef DATAGRAM_CHECKSUM_EN
          CHECK: begin
            if (rx_valid) begin
              state <= IDLE;
              busy  <= 1'b0;
              tcnt  <= '0;
            end else begin
              tcnt <= tcnt + TO_W'(1);
            end
          end
`endif
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
